// File: rtl/waypoint_streamer.sv
// waypoint_streamer: streams stored x/y waypoints with Manhattan step distance and last flag.
// Optional closed-tour segment back to waypoint 0 under WAYPOINT_STREAMER_LOOP_EN.
module waypoint_streamer #(
  parameter int COORD_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  num_coords,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rden,
  input  logic [COORD_W-1:0] x_q,
  input  logic [COORD_W-1:0] y_q,
  output logic [COORD_W-1:0] wp_x,
  output logic [COORD_W-1:0] wp_y,
  output logic [COORD_W:0]   wp_dist,
  output logic               wp_valid,
  input  logic               wp_ready,
  output logic               wp_last,
  output logic               busy,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, FINISH} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [COORD_W-1:0] px, py;
  logic [1:0] wcnt;
  logic last_q, cap, hs, at_end, first;
  function automatic logic [COORD_W:0] mdist(input logic [COORD_W-1:0] a, b, c, d);
    mdist = {1'b0, a > b ? a - b : b - a} + {1'b0, c > d ? c - d : d - c};
  endfunction
  assign cap = state == WAIT && wcnt == 2'd1;
  assign hs = state == PRESENT && wp_ready;
  assign at_end = mem_addr == cnt - ADDR_W'(1);
  assign first = mem_addr == '0;
  assign mem_rden = state == ISSUE;
  assign wp_valid = state == PRESENT;
  assign wp_last = state == PRESENT && last_q;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = num_coords != '0 ? ISSUE : FINISH;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cap) state_nxt = PRESENT;
      PRESENT: if (hs) state_nxt = last_q ? FINISH : at_end ? PRESENT : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end
`ifdef WAYPOINT_STREAMER_LOOP_EN
  logic [COORD_W-1:0] x0, y0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x0 <= '0;
      y0 <= '0;
    end else if (cap && first) begin
      x0 <= x_q;
      y0 <= y_q;
    end
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_addr <= '0;
      cnt <= '0;
      wp_x <= '0;
      wp_y <= '0;
      wp_dist <= '0;
      px <= '0;
      py <= '0;
      wcnt <= '0;
      last_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= num_coords;
        mem_addr <= '0;
      end
      wcnt <= state == ISSUE ? 2'(RD_LAT) : state == WAIT ? wcnt - 2'd1 : wcnt;
      if (cap) begin
        wp_x <= x_q;
        wp_y <= y_q;
        wp_dist <= first ? '0 : mdist(x_q, px, y_q, py);
`ifdef WAYPOINT_STREAMER_LOOP_EN
        last_q <= 1'b0;
`else
        last_q <= at_end;
`endif
      end
`ifdef WAYPOINT_STREAMER_LOOP_EN
      // closing segment reuses the present slot instead of rereading memory
      if (hs && !last_q && at_end) begin
        wp_x <= x0;
        wp_y <= y0;
        wp_dist <= mdist(wp_x, x0, wp_y, y0);
        last_q <= 1'b1;
      end else if (hs && !last_q) begin
        px <= wp_x;
        py <= wp_y;
        mem_addr <= mem_addr + ADDR_W'(1);
      end
`else
      if (hs && !last_q) begin
        px <= wp_x;
        py <= wp_y;
        mem_addr <= mem_addr + ADDR_W'(1);
      end
`endif
      if (state == FINISH) last_q <= 1'b0;
    end
endmodule

// File: tb/tb_waypoint_streamer.sv
// tb_waypoint_streamer: scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances in lockstep.
module tb_waypoint_streamer;
`ifdef WAYPOINT_STREAMER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 0, reset = 0, start = 0;
  logic [7:0] num = 0;
  always #5 clk = ~clk;
  logic [7:0] mx [256], my [256];
  logic [7:0] addr [2], wx [2], wy [2], d1x [2], d1y [2], d2x, d2y;
  logic [8:0] wd [2];
  logic rden [2], valid [2], last [2], busy [2], done [2], rdy [2];
  typedef struct packed {logic [7:0] x, y; logic [8:0] d; logic l, g;} exp_t;
  exp_t exp_q [$];
  exp_t e;
  int idx [2], rexp [2], rd_cnt [2], done_cnt [2], busy_cnt [2], sc [2], last_hs [2];
  int cyc, mode, checks, errors;

  waypoint_streamer #(.COORD_W(8), .ADDR_W(8), .RD_LAT(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .num_coords(num), .mem_addr(addr[0]),
    .mem_rden(rden[0]), .x_q(d1x[0]), .y_q(d1y[0]), .wp_x(wx[0]), .wp_y(wy[0]),
    .wp_dist(wd[0]), .wp_valid(valid[0]), .wp_ready(rdy[0]), .wp_last(last[0]),
    .busy(busy[0]), .done(done[0]));
  waypoint_streamer #(.COORD_W(8), .ADDR_W(8), .RD_LAT(2)) u1 (
    .clk(clk), .reset(reset), .start(start), .num_coords(num), .mem_addr(addr[1]),
    .mem_rden(rden[1]), .x_q(d2x), .y_q(d2y), .wp_x(wx[1]), .wp_y(wy[1]),
    .wp_dist(wd[1]), .wp_valid(valid[1]), .wp_ready(rdy[1]), .wp_last(last[1]),
    .busy(busy[1]), .done(done[1]));

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rden[i]) begin
        d1x[i] <= mx[addr[i]];
        d1y[i] <= my[addr[i]];
      end
    d2x <= d1x[1];
    d2y <= d1y[1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int x, input int y, input int d, input bit l, input bit g);
    exp_q.push_back({8'(x), 8'(y), 9'(d), l, g});
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_outputs%0d", tag, i),
          {addr[i], rden[i], wx[i], wy[i], wd[i], valid[i], last[i], busy[i], done[i]}, 0);
  endtask

  task automatic run(input int n, input int m);
    int r0 [2], dn0 [2], b0 [2];
    for (int i = 0; i < 2; i++) begin
      r0[i] = rd_cnt[i];
      dn0[i] = done_cnt[i];
      b0[i] = busy_cnt[i];
    end
    mode = m;
    @(negedge clk);
    start = 1;
    num = 8'(n);
    @(negedge clk);
    start = 0;
    num = 8'hAA;
    if (n == 0)
      for (int i = 0; i < 2; i++) chk($sformatf("zero_done_timing%0d", i), done[i], 1);
    else begin
      repeat (2) @(negedge clk);
      start = 1;
      num = 8'd5;
      @(negedge clk);
      start = 0;
    end
    for (int t = 0; t < 500 && !(done_cnt[0] > dn0[0] && done_cnt[1] > dn0[1]); t++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("done_pulses%0d", i), done_cnt[i] - dn0[i], 1);
      chk($sformatf("rden_pulses%0d", i), rd_cnt[i] - r0[i], n);
      chk($sformatf("waypoints_consumed%0d", i), idx[i], exp_q.size());
      if (n == 0) chk($sformatf("zero_busy_cycles%0d", i), busy_cnt[i] - b0[i], 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rdy[i] = 0;
      idx[i] = 0;
      rexp[i] = 0;
      rd_cnt[i] = 0;
      done_cnt[i] = 0;
      busy_cnt[i] = 0;
      sc[i] = 0;
      last_hs[i] = 0;
    end
    cyc = 0;
    mode = 0;
    checks = 0;
    errors = 0;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
          if (!busy[i]) rexp[i] = 0;
          busy_cnt[i] += int'(busy[i]);
          if (done[i]) done_cnt[i]++;
          if (rden[i]) begin
            chk($sformatf("mem_addr%0d", i), addr[i], rexp[i]);
            rexp[i]++;
            rd_cnt[i]++;
          end
          if (!valid[i]) begin
            chk($sformatf("last_without_valid%0d", i), last[i], 0);
            rdy[i] = mode == 0;
          end else if (mode != 2) begin
            if (idx[i] >= exp_q.size()) begin
              checks++;
              errors++;
              $display("FAIL extra_waypoint%0d: got (%0d,%0d) expected none", i, wx[i], wy[i]);
            end else begin
              e = exp_q[idx[i]];
              chk($sformatf("wp_x%0d[%0d]", i, idx[i]), wx[i], e.x);
              chk($sformatf("wp_y%0d[%0d]", i, idx[i]), wy[i], e.y);
              chk($sformatf("wp_dist%0d[%0d]", i, idx[i]), wd[i], e.d);
              chk($sformatf("wp_last%0d[%0d]", i, idx[i]), last[i], e.l);
            end
            if (mode == 1 && sc[i] < 5) begin
              rdy[i] = 0;
              sc[i]++;
            end else begin
              rdy[i] = 1;
              sc[i] = 0;
            end
            if (rdy[i]) begin
              if (mode == 0 && idx[i] < exp_q.size() && exp_q[idx[i]].g)
                chk($sformatf("cycles_per_wp%0d", i), cyc - last_hs[i], 3 + i);
              last_hs[i] = cyc;
              idx[i]++;
            end
          end else rdy[i] = 0;
        end
      end
    join_none
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1;
    // abort a run while waypoint 0 is held in PRESENT
    mx[0] = 10; my[0] = 20; mx[1] = 13; my[1] = 16; mx[2] = 0; my[2] = 255;
    mode = 2;
    @(negedge clk);
    start = 1;
    num = 3;
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 50 && !(valid[0] && valid[1]); t++) @(negedge clk);
    chk("abort_reached_present", {valid[0], valid[1]}, 2'b11);
    reset = 0;
    @(negedge clk);
    chk_idle("midreset");
    @(negedge clk);
    chk_idle("midreset_hold");
    reset = 1;
    chk("abort_no_done0", done_cnt[0], 0);
    chk("abort_no_done1", done_cnt[1], 0);
    mx[0] = 5; my[0] = 5;
    push(5, 5, 0, !LOOP, 0);
    if (LOOP) push(5, 5, 0, 1, 0);
    run(1, 0);
    mx[0] = 10; my[0] = 20;
    for (int s = 0; s < 2; s++) begin
      push(10, 20, 0, 0, 0);
      push(13, 16, 7, 0, s == 0);
      push(0, 255, 252, !LOOP, s == 0);
      if (LOOP) push(10, 20, 245, 1, 0);
      run(3, s);
    end
    run(0, 0);
    mx[0] = 0; my[0] = 0; mx[1] = 255; my[1] = 255;
    push(0, 0, 0, 0, 0);
    push(255, 255, 510, !LOOP, 1);
    if (LOOP) push(0, 0, 510, 1, 0);
    run(2, 0);
    mx[0] = 7; my[0] = 9; mx[1] = 7; my[1] = 9;
    push(7, 9, 0, 0, 0);
    push(7, 9, 0, !LOOP, 1);
    if (LOOP) push(7, 9, 0, 1, 0);
    run(2, 0);
`ifdef WAYPOINT_STREAMER_LOOP_EN
    mx[0] = 1; my[0] = 1; mx[1] = 4; my[1] = 5;
    push(1, 1, 0, 0, 0);
    push(4, 5, 7, 0, 1);
    push(1, 1, 7, 1, 0);
    run(2, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/waypoint_streamer.md
Name: waypoint_streamer

Overview:
- Downstream of the coordinate collector. Once the collector finishes, this block reads the stored waypoints back from the x/y coordinate memories in address order.
- Presents each waypoint to the pathfinding core on a valid/ready stream.
- Attaches to each waypoint the Manhattan distance from the previous one and a last-waypoint flag.

Parameters:
COORD_W, 8, width of each x/y coordinate and of each memory data word
ADDR_W, 8, width of the memory address and of the waypoint count
RD_LAT, 1, memory read latency in cycles (legal values 1 or 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin streaming; sampled only in IDLE (driven from the collector's done)
num_coords  in  ADDR_W  number of stored waypoints; latched when start is accepted
mem_addr  out  ADDR_W  read address, shared by the x and y memories
mem_rden  out  1  read enable, one-cycle pulse per read
x_q  in  COORD_W  x memory read data, valid RD_LAT cycles after mem_rden
y_q  in  COORD_W  y memory read data, same timing as x_q
wp_x  out  COORD_W  waypoint x
wp_y  out  COORD_W  waypoint y
wp_dist  out  COORD_W+1  Manhattan distance |x-xprev|+|y-yprev|; 0 for the first waypoint
wp_valid  out  1  waypoint on wp_* is valid
wp_ready  in  1  consumer accepts the waypoint
wp_last  out  1  high together with wp_valid on the final waypoint
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when streaming completes

Behaviour:
- Reset (reset=0, async): state=IDLE. mem_addr, wp_x, wp_y, wp_dist, the count register and the prev registers =0. mem_rden, wp_valid, wp_last, busy, done =0.
- States: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE:
  - start=1 and num_coords≠0: latch num_coords, mem_addr=0, go to ISSUE.
  - start=1 and num_coords=0: go directly to FINISH; no read is issued.
- ISSUE:
  - mem_rden=1 for exactly one cycle, then go to WAIT.
  - A wait counter is loaded with RD_LAT.
- WAIT:
  - Stay until RD_LAT cycles have elapsed since mem_rden.
  - On the capture cycle: register x_q→wp_x and y_q→wp_y.
  - Compute wp_dist with unsigned absolute differences, zero-extended to COORD_W+1 bits before summing, so it never overflows. Maximum value is 2*(2^COORD_W-1).
  - First waypoint of a run: wp_dist=0.
  - wp_last = (mem_addr == latched count - 1). Go to PRESENT.
- PRESENT:
  - wp_valid=1. wp_x, wp_y, wp_dist and wp_last stay stable until the handshake.
  - Handshake occurs when wp_valid & wp_ready on a rising edge. wp_ready may be high before valid.
  - On handshake with wp_last=1: go to FINISH.
  - On handshake otherwise: prev←(wp_x,wp_y), mem_addr+1, go to ISSUE.
  - wp_valid drops in the cycle after the handshake.
  - Throughput: one waypoint per 2+RD_LAT cycles, given ready held high.
- FINISH:
  - done=1 for one cycle. wp_valid, wp_last=0. Return to IDLE; busy=0 from then.
- start while not in IDLE is ignored. num_coords changes after latching are ignored.
- mem_addr never exceeds count-1. No address wrap occurs, except under the optional feature.
- Reset asserted mid-stream: immediate return to IDLE with reset values. No done pulse is generated.
- A waypoint with identical coordinates to the previous one is legal and gives wp_dist=0.

Optional Feature:
- Macro: WAYPOINT_STREAMER_LOOP_EN.
- Defined: closed-tour mode.
  - After the last waypoint's handshake, a final extra segment is presented: wp_x/wp_y = waypoint 0, and wp_dist = distance from the last waypoint back to waypoint 0.
  - This needs waypoint 0 held in a register captured on the first read. No memory reread.
  - wp_last=1 moves to this closing segment; the real last waypoint carries wp_last=0.
  - Then go to FINISH.
  - num_coords=1: closing segment repeats waypoint 0 with wp_dist=0.
- Undefined: behaviour exactly as above. The waypoint-0 register is not instantiated.

Test Plan:
- Reset mid-PRESENT, with reset low for 2 cycles → all outputs 0, state IDLE. A subsequent start with num_coords=1 and memory {(5,5)} streams (5,5), dist 0, last=1, then one done pulse.
- num_coords=3, memory {(10,20),(13,16),(0,255)}, wp_ready tied 1 → waypoints (10,20,d0),(13,16,d7),(0,255,d252), wp_last only on the third; done pulses once; mem_addr sequence 0,1,2; exactly 3 mem_rden pulses.
- Same data, wp_ready low for 5 cycles at each valid → wp_* stable throughout the stall; no extra mem_rden; same outputs as the previous case.
- start with num_coords=0 → no mem_rden, no wp_valid, done pulses 1 cycle after start, busy high for exactly one cycle.
- Max distance: memory {(0,0),(255,255)} → second waypoint has wp_dist=510 (9'h1FE), no truncation. Repeat with RD_LAT=2 → identical stream, 4 cycles per waypoint.
- LOOP_EN defined, num_coords=2 {(1,1),(4,5)} → (1,1,d0,last0),(4,5,d7,last0),(1,1,d7,last1), then done.
